// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and helpers.
// Also imported by the decode stage and the debug unit.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_RESET   = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_JUMP,
    REDIR_JR,
    REDIR_BRANCH
  } redir_e;

  function automatic logic [XLEN-1:0] pc_plus4(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_stage_instruction_memory.sv
// Instruction store: one synchronous write port (debug unit),
// one asynchronous read port (fetch). Never cleared by reset.
module instruction_memory #(
  parameter int BITS_SIZE = 32,
  parameter int MEM_DEPTH = 256,
  parameter int BITS_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [BITS_ADDR-1:0] i_wr_addr,
  input  logic [BITS_SIZE-1:0] i_wr_data,
  input  logic [BITS_ADDR-1:0] i_rd_addr,
  output logic [BITS_SIZE-1:0] o_rd_data
);

  logic [BITS_SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect select,
// IF/ID latch and sticky halt detection.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int MEM_DEPTH = 256,
  parameter int BITS_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_flag_jump,
  input  logic [BITS_SIZE-1:0] i_jump_addr,
  input  logic                 i_flag_jr,
  input  logic [BITS_SIZE-1:0] i_jr_addr,
  input  logic                 i_flag_branch,
  input  logic [BITS_SIZE-1:0] i_branch_addr,
  input  logic                 i_dbg_wr_en,
  input  logic [BITS_ADDR-1:0] i_dbg_wr_addr,
  input  logic [BITS_SIZE-1:0] i_dbg_wr_data,
  output logic [BITS_SIZE-1:0] o_pc,
  output logic [BITS_SIZE-1:0] o_ifid_pc4,
  output logic [BITS_SIZE-1:0] o_ifid_instr,
  output logic                 o_halt
);

  logic [BITS_SIZE-1:0] pc;
  logic [BITS_SIZE-1:0] pc4;
  logic [BITS_SIZE-1:0] ifid_pc4;
  logic [BITS_SIZE-1:0] ifid_instr;
  logic                 halt;
  logic [BITS_SIZE-1:0] fetch_word;
  logic [BITS_SIZE-1:0] redir_addr;
  redir_e               redir_sel;
  logic                 advance;
  logic                 fetch_is_halt;

  instruction_memory #(
    .BITS_SIZE (BITS_SIZE),
    .MEM_DEPTH (MEM_DEPTH),
    .BITS_ADDR (BITS_ADDR)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (i_dbg_wr_en),
    .i_wr_addr (i_dbg_wr_addr),
    .i_wr_data (i_dbg_wr_data),
    .i_rd_addr (pc[BITS_ADDR+1:2]),
    .o_rd_data (fetch_word)
  );

  assign pc4           = pc + BITS_SIZE'(4);
  assign advance       = i_step && !halt;
  assign fetch_is_halt = (fetch_word == BITS_SIZE'(HALT_INSTR));

  // jump > jr > branch
  always_comb begin
    redir_sel  = REDIR_NONE;
    redir_addr = pc;
    unique case (1'b1)
      i_flag_jump: begin
        redir_sel  = REDIR_JUMP;
        redir_addr = i_jump_addr;
      end
      (!i_flag_jump && i_flag_jr): begin
        redir_sel  = REDIR_JR;
        redir_addr = i_jr_addr;
      end
      (!i_flag_jump && !i_flag_jr && i_flag_branch): begin
        redir_sel  = REDIR_BRANCH;
        redir_addr = i_branch_addr;
      end
      default: begin
        redir_sel  = REDIR_NONE;
        redir_addr = pc;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc         <= BITS_SIZE'(PC_RESET);
      ifid_pc4   <= '0;
      ifid_instr <= BITS_SIZE'(NOP_INSTR);
      halt       <= 1'b0;
    end else if (advance) begin
      if (redir_sel != REDIR_NONE) begin
        pc         <= redir_addr;
        ifid_pc4   <= '0;
        ifid_instr <= BITS_SIZE'(NOP_INSTR);
      end else if (!i_stall) begin
        ifid_pc4   <= pc4;
        ifid_instr <= fetch_word;
        // PC parks on the HALT word so debug readout shows it
        if (fetch_is_halt) begin
          halt <= 1'b1;
        end else begin
          pc <= pc4;
        end
      end
    end
  end

  assign o_pc         = pc;
  assign o_ifid_pc4   = ifid_pc4;
  assign o_ifid_instr = ifid_instr;
  assign o_halt       = halt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a cycle-level reference
// model and per-cycle output comparison.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic        stall;
  logic        f_jump;
  logic [31:0] jump_addr;
  logic        f_jr;
  logic [31:0] jr_addr;
  logic        f_branch;
  logic [31:0] branch_addr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        halt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_mem [256];
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_pc4   = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_halt  = 1'b0;

  if_stage dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_step        (step),
    .i_stall       (stall),
    .i_flag_jump   (f_jump),
    .i_jump_addr   (jump_addr),
    .i_flag_jr     (f_jr),
    .i_jr_addr     (jr_addr),
    .i_flag_branch (f_branch),
    .i_branch_addr (branch_addr),
    .i_dbg_wr_en   (wr_en),
    .i_dbg_wr_addr (wr_addr),
    .i_dbg_wr_data (wr_data),
    .o_pc          (pc),
    .o_ifid_pc4    (ifid_pc4),
    .o_ifid_instr  (ifid_instr),
    .o_halt        (halt)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: what one rising edge must do.
  always @(posedge clk) begin
    logic [31:0] fetched;
    fetched = m_mem[m_pc[9:2]];
    if (wr_en) m_mem[wr_addr] = wr_data;
    if (reset) begin
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_halt = 0;
    end else if (step && !m_halt) begin
      if (f_jump || f_jr || f_branch) begin
        m_pc = f_jump ? jump_addr : f_jr ? jr_addr : branch_addr;
        m_pc4 = 0;
        m_instr = 0;
      end else if (!stall) begin
        m_instr = fetched;
        m_pc4 = m_pc + 4;
        if (fetched == 32'hFFFF_FFFF) m_halt = 1;
        else m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("ifid_pc4", ifid_pc4, m_pc4);
      check("ifid_instr", ifid_instr, m_instr);
      check("halt", {31'b0, halt}, {31'b0, m_halt});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_redir();
    f_jump = 0; f_jr = 0; f_branch = 0;
  endtask

  initial begin
    reset = 1; step = 0; stall = 0;
    f_jump = 0; f_jr = 0; f_branch = 0;
    jump_addr = 0; jr_addr = 0; branch_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    @(negedge clk);

    // Load memory while in reset
    for (int i = 0; i < 256; i++) begin
      wr_en = 1;
      wr_addr = 8'(i);
      if (i < 4) wr_data = 32'h1111_1111 * (i + 1);
      else if (i == 5) wr_data = 32'hFFFF_FFFF;
      else wr_data = 32'hA500_0000 | 32'(i);
      tick();
    end
    wr_en = 0;
    tick();
    chk_en = 1;
    check("reset_pc", pc, 32'h0);
    check("reset_instr", ifid_instr, 32'h0);
    reset = 0;

    step = 1;
    ticks(3);
    check("run3_pc", pc, 32'hC);
    check("run3_instr", ifid_instr, 32'h3333_3333);
    check("run3_pc4", ifid_pc4, 32'hC);

    // step low: nothing moves, even with a redirect present
    step = 0; f_jump = 1; jump_addr = 32'h100;
    ticks(5);
    clr_redir();
    check("nostep_pc", pc, 32'hC);
    check("nostep_instr", ifid_instr, 32'h3333_3333);

    // back to 0x8, then stall
    reset = 1; step = 1;
    tick();
    reset = 0;
    ticks(2);
    check("prestall_pc", pc, 32'h8);
    stall = 1;
    ticks(2);
    check("stall_pc", pc, 32'h8);
    check("stall_instr", ifid_instr, 32'h2222_2222);
    stall = 0;
    tick();
    check("release_pc", pc, 32'hC);
    check("release_instr", ifid_instr, 32'h3333_3333);

    // jump beats branch, and overrides stall
    f_jump = 1; jump_addr = 32'h40;
    f_branch = 1; branch_addr = 32'h80;
    stall = 1;
    tick();
    clr_redir(); stall = 0;
    check("jump_pc", pc, 32'h40);
    check("jump_flush", ifid_instr, 32'h0);
    tick();
    check("after_jump_instr", ifid_instr, 32'hA500_0010);

    // jr beats branch
    f_jr = 1; jr_addr = 32'h20; f_branch = 1; branch_addr = 32'h80;
    tick();
    clr_redir();
    check("jr_pc", pc, 32'h20);

    // PC wrap and word-index wrap
    f_jump = 1; jump_addr = 32'hFFFF_FFFC;
    tick();
    clr_redir();
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_instr", ifid_instr, 32'hA500_00FF);

    // write/fetch collision on word 2
    f_branch = 1; branch_addr = 32'h8;
    tick();
    clr_redir();
    wr_en = 1; wr_addr = 8'd2; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 0;
    check("coll_old", ifid_instr, 32'h3333_3333);
    f_jump = 1; jump_addr = 32'h8;
    tick();
    clr_redir();
    tick();
    check("coll_new", ifid_instr, 32'hDEAD_BEEF);

    // run to HALT at word 5; stalled HALT fetch must not halt
    ticks(2);
    check("prehalt_pc", pc, 32'h14);
    stall = 1;
    tick();
    stall = 0;
    check("stall_nohalt", {31'b0, halt}, 32'h0);
    tick();
    check("halt_set", {31'b0, halt}, 32'h1);
    check("halt_pc", pc, 32'h14);
    f_jump = 1; jump_addr = 32'h40; f_jr = 1;
    ticks(3);
    clr_redir();
    check("halt_hold_pc", pc, 32'h14);

    // reset clears halt; concurrent debug write completes
    reset = 1;
    wr_en = 1; wr_addr = 8'd0; wr_data = 32'h5555_5555;
    tick();
    reset = 0; wr_en = 0;
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_pc", pc, 32'h0);
    tick();
    check("rst_wr_instr", ifid_instr, 32'h5555_5555);
    check("rst_wr_pc", pc, 32'h4);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- BITS_SIZE, 32, datapath/instruction width.
- MEM_DEPTH, 256, instruction memory depth in words.
- BITS_ADDR, 8, word-index width (log2 MEM_DEPTH).
REQ-002 Ports SHALL be (name  direction  width  meaning), clock and reset first:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high.
- i_step  in  1  advance enable from debug unit; no pipeline state changes while 0.
- i_stall  in  1  hazard-unit hold of PC and IF/ID.
- i_flag_jump  in  1  J/JAL redirect, target i_jump_addr.
- i_jump_addr  in  BITS_SIZE  jump target computed in ID.
- i_flag_jr  in  1  JR/JALR redirect, target i_jr_addr.
- i_jr_addr  in  BITS_SIZE  register-sourced target.
- i_flag_branch  in  1  taken-branch redirect, target i_branch_addr.
- i_branch_addr  in  BITS_SIZE  branch target.
- i_dbg_wr_en  in  1  debug-unit instruction-memory write.
- i_dbg_wr_addr  in  BITS_ADDR  word index for write.
- i_dbg_wr_data  in  BITS_SIZE  instruction word to write.
- o_pc  out  BITS_SIZE  current PC (byte address), also for debug readout.
- o_ifid_pc4  out  BITS_SIZE  IF/ID latched PC+4, feeds ID.
- o_ifid_instr  out  BITS_SIZE  IF/ID latched instruction, feeds ID field decode.
- o_halt  out  1  sticky; HALT instruction reached IF/ID.

Function
REQ-003 Fetch SHALL read memory combinationally at word index o_pc[BITS_ADDR+1:2]; upper PC bits ignored (index wraps modulo MEM_DEPTH).
REQ-004 PC+4 SHALL be computed modulo 2^BITS_SIZE (0xFFFFFFFC -> 0x00000000).
REQ-005 Updates SHALL occur only on rising edges with i_step=1 and o_halt=0; otherwise PC and IF/ID hold.
REQ-006 Redirect priority SHALL be jump > jr > branch; any redirect is a single event.
REQ-007 On redirect: PC <= selected target, IF/ID <= NOP (instr 0x00000000, pc4 0) next cycle, i.e. a one-bubble flush; redirect overrides i_stall.
REQ-008 On i_stall=1 with no redirect: PC and IF/ID hold.
REQ-009 Otherwise: PC <= PC+4, o_ifid_instr <= fetched word, o_ifid_pc4 <= PC+4; latency fetch-to-IF/ID = 1 cycle.
REQ-010 HALT encoding SHALL be 0xFFFFFFFF; when HALT is loaded into IF/ID per REQ-009, o_halt <= 1 on the same edge and PC holds at the HALT address.
REQ-011 HALT fetched in a cycle with redirect or stall SHALL NOT set o_halt.
REQ-012 Once o_halt=1, all redirects, stalls and steps SHALL be ignored until reset.
REQ-013 Debug writes SHALL occur on any rising edge with i_dbg_wr_en=1, independent of i_step and o_halt; write and fetch of the same word in one cycle returns old data.

Reset
REQ-014 On i_reset=1 at an edge: o_pc=0, o_ifid_pc4=0, o_ifid_instr=0x00000000, o_halt=0; overrides step, stall, redirect mid-operation.
REQ-015 Instruction memory contents SHALL NOT be cleared by reset; a debug write concurrent with reset SHALL complete.

Structure
REQ-016 Shared package SHALL hold HALT_INSTR (0xFFFFFFFF), NOP_INSTR (0x00000000) and PC_RESET (0) for reuse by ID and the debug unit.
REQ-017 Memory SHALL be a sub-module instruction_memory (one write port, one asynchronous read port); PC/IF-ID logic stays in if_stage.

Verification
REQ-018 Bench SHALL cover:
- Load words 0..3 = 0x11111111..0x44444444, reset, step 3 -> o_pc 0xC, o_ifid_instr 0x33333333, o_ifid_pc4 0xC.
- i_step=0 for 5 cycles mid-run -> o_pc, IF/ID unchanged.
- At PC 0x8 assert i_stall 2 cycles -> o_pc stays 0x8, IF/ID holds; release -> resumes 0xC.
- jump 0x40 and branch 0x80 same cycle with stall -> o_pc 0x40, o_ifid_instr 0x00000000 next cycle.
- Word 5 = 0xFFFFFFFF, run -> o_halt=1 with o_pc 0x14; further steps/redirects leave o_pc 0x14; reset clears o_halt, o_pc 0.
- Debug write to word 2 while fetching word 2 -> old word latched; refetch after redirect to 0x8 returns new word.
